// File: rtl/pe_pkg.sv
// Shared types, Kyber/Dilithium constants and config decode for the modular-arithmetic PE array.
package pe_pkg;

  typedef enum logic [4:0] {
    MADD   = 5'd0,
    MSUB   = 5'd1,
    CT_BFO = 5'd2,
    P2R    = 5'd3,
    CHKZ   = 5'd4,
    CHKW0  = 5'd5,
    CHKH   = 5'd6
  } pe_instr_t;

  typedef enum logic [4:0] {
    KEM_512  = 5'd0,
    KEM_768  = 5'd1,
    KEM_1024 = 5'd2,
    DSA_44   = 5'd3,
    DSA_65   = 5'd4,
    DSA_87   = 5'd5
  } pe_alg_t;

  localparam int CW = 24;

  localparam logic [CW-1:0] Q_KEM   = 24'd3329;
  localparam logic [CW-1:0] Q_DSA   = 24'd8380417;
  localparam int            D_DSA   = 13;

  localparam logic [CW-1:0] G1_44   = 24'd131072;
  localparam logic [CW-1:0] G1_65   = 24'd524288;
  localparam logic [CW-1:0] G1_87   = 24'd524288;
  localparam logic [CW-1:0] G2_44   = 24'd95232;
  localparam logic [CW-1:0] G2_65   = 24'd261888;
  localparam logic [CW-1:0] G2_87   = 24'd261888;
  localparam logic [CW-1:0] BETA_44 = 24'd78;
  localparam logic [CW-1:0] BETA_65 = 24'd196;
  localparam logic [CW-1:0] BETA_87 = 24'd120;

  // Bounds are pre-subtracted so each lane only compares.
  typedef struct packed {
    logic          is_dsa;
    logic [CW-1:0] q;
    logic [CW-1:0] bnd_z;
    logic [CW-1:0] bnd_w0;
    logic [CW-1:0] bnd_h;
  } pe_cfg_t;

  function automatic pe_cfg_t pe_cfg_from_alg(input pe_alg_t alg);
    pe_cfg_t c;
    c = '0;
    case (alg)
      DSA_44: begin
        c.is_dsa = 1'b1; c.q = Q_DSA;
        c.bnd_z = G1_44 - BETA_44; c.bnd_w0 = G2_44 - BETA_44; c.bnd_h = G2_44;
      end
      DSA_65: begin
        c.is_dsa = 1'b1; c.q = Q_DSA;
        c.bnd_z = G1_65 - BETA_65; c.bnd_w0 = G2_65 - BETA_65; c.bnd_h = G2_65;
      end
      DSA_87: begin
        c.is_dsa = 1'b1; c.q = Q_DSA;
        c.bnd_z = G1_87 - BETA_87; c.bnd_w0 = G2_87 - BETA_87; c.bnd_h = G2_87;
      end
      default: c.q = Q_KEM;
    endcase
    return c;
  endfunction

  // Rounding and norm checks only have meaning under a Dilithium config.
  function automatic logic pe_instr_ok(input pe_instr_t op, input logic is_dsa);
    case (op)
      MADD, MSUB, CT_BFO:       return 1'b1;
      P2R, CHKZ, CHKW0, CHKH:   return is_dsa;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pe_modarith_lane.sv
// Single-lane 2-stage modular datapath: stage 1 raw sum/diff/compares, stage 2 correction.
module pe_modarith_lane
  import pe_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  pe_cfg_t          cfg,
  input  pe_instr_t        instr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             fail
);

  localparam logic [WIDTH:0] RND = (WIDTH+1)'((1 << (D_DSA - 1)) - 1);

  logic [WIDTH-1:0] q, bnd;
  logic [WIDTH:0]   s_d, s_q, d_d, d_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic             ge_d, ge_q, hit_d, hit_q, ok_d, ok_q;
  pe_instr_t        op_d, op_q;

  logic [WIDTH:0]   madd, msub, rnd;
  logic [WIDTH-1:0] px;
  logic [WIDTH-1:0] x_d, x_q, y_d, y_q;
  logic             fail_d, fail_q;

  assign q = WIDTH'(cfg.q);

  always_comb begin
    case (instr)
      CHKZ:    bnd = WIDTH'(cfg.bnd_z);
      CHKW0:   bnd = WIDTH'(cfg.bnd_w0);
      default: bnd = WIDTH'(cfg.bnd_h);
    endcase
    a_d   = a;
    op_d  = instr;
    s_d   = {1'b0, a} + {1'b0, b};
    d_d   = {1'b0, a} - {1'b0, b};
    ge_d  = s_d >= {1'b0, q};
    hit_d = (a >= bnd) && (a <= q - bnd);
    ok_d  = pe_instr_ok(instr, cfg.is_dsa);
  end

  // d_q is two's complement in WIDTH+1 bits; its MSB is the borrow.
  always_comb begin
    madd   = ge_q ? s_q - {1'b0, q} : s_q;
    msub   = d_q[WIDTH] ? d_q + {1'b0, q} : d_q;
    rnd    = {1'b0, a_q} + RND;
    px     = WIDTH'(rnd >> D_DSA);
    x_d    = '0;
    y_d    = '0;
    fail_d = 1'b0;
    if (ok_q) begin
      case (op_q)
        MADD:   x_d = madd[WIDTH-1:0];
        MSUB:   x_d = msub[WIDTH-1:0];
        CT_BFO: begin
          x_d = madd[WIDTH-1:0];
          y_d = msub[WIDTH-1:0];
        end
        P2R: begin
          x_d = px;
          y_d = a_q - (px << D_DSA);
        end
        CHKZ, CHKW0, CHKH: begin
          x_d    = WIDTH'(hit_q);
          fail_d = hit_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      d_q    <= '0;
      a_q    <= '0;
      ge_q   <= 1'b0;
      hit_q  <= 1'b0;
      ok_q   <= 1'b0;
      op_q   <= MADD;
      x_q    <= '0;
      y_q    <= '0;
      fail_q <= 1'b0;
    end else if (en) begin
      s_q    <= s_d;
      d_q    <= d_d;
      a_q    <= a_d;
      ge_q   <= ge_d;
      hit_q  <= hit_d;
      ok_q   <= ok_d;
      op_q   <= op_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fail_q <= fail_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign fail = fail_q;

endmodule

// File: rtl/pe_modarith_pipe.sv
// NUM-lane modular-arithmetic PE with handshakes, config latch and sticky per-packet check verdict.
// Define PE_IN_SKID_EN to add a one-entry input skid buffer and register in_ready.
module pe_modarith_pipe
  import pe_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [4:0]           cfg_alg,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_instr,
  input  logic                 in_last,
  input  logic [NUM*WIDTH-1:0] in_a,
  input  logic [NUM*WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM*WIDTH-1:0] out_x,
  output logic [NUM*WIDTH-1:0] out_y,
  output logic                 out_last,
  output logic                 out_chk_fail,
  output logic                 out_err,
  output logic                 busy
);

  typedef logic [NUM-1:0][WIDTH-1:0] vec_t;

  logic       advance, in_fire, out_fire, cur_fail;
  logic       src_vld, src_last;
  logic [4:0] src_instr;
  vec_t       src_a, src_b, lx, ly;
  logic [NUM-1:0] lfail;

  logic [1:0] vld_pipe_d, vld_pipe_q, last_pipe_d, last_pipe_q, err_pipe_d, err_pipe_q;
  logic       acc_d, acc_q;
  pe_cfg_t    cfg_d, cfg_q;

  assign advance  = !vld_pipe_q[1] || out_ready;
  assign out_fire = vld_pipe_q[1] && out_ready;

`ifdef PE_IN_SKID_EN
  logic       skid_full_d, skid_full_q, skid_last_d, skid_last_q;
  logic [4:0] skid_instr_d, skid_instr_q;
  vec_t       skid_a_d, skid_a_q, skid_b_d, skid_b_q;

  assign in_ready = !skid_full_q;
  assign in_fire  = in_valid && !skid_full_q;
  assign busy     = skid_full_q || (|vld_pipe_q);

  // A held entry always feeds the pipe ahead of the live input.
  always_comb begin
    src_vld      = skid_full_q || in_fire;
    src_last     = skid_full_q ? skid_last_q  : in_last;
    src_instr    = skid_full_q ? skid_instr_q : in_instr;
    src_a        = skid_full_q ? skid_a_q     : in_a;
    src_b        = skid_full_q ? skid_b_q     : in_b;
    skid_full_d  = !advance && (skid_full_q || in_fire);
    skid_last_d  = skid_last_q;
    skid_instr_d = skid_instr_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    if (!advance && in_fire) begin
      skid_last_d  = in_last;
      skid_instr_d = in_instr;
      skid_a_d     = in_a;
      skid_b_d     = in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full_q  <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_instr_q <= '0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
    end else begin
      skid_full_q  <= skid_full_d;
      skid_last_q  <= skid_last_d;
      skid_instr_q <= skid_instr_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
    end
  end
`else
  assign in_ready  = advance;
  assign in_fire   = in_valid && advance;
  assign busy      = |vld_pipe_q;
  assign src_vld   = in_fire;
  assign src_last  = in_last;
  assign src_instr = in_instr;
  assign src_a     = in_a;
  assign src_b     = in_b;
`endif

  assign cfg_ready = !busy;

  always_comb begin
    cur_fail    = |lfail;
    vld_pipe_d  = vld_pipe_q;
    last_pipe_d = last_pipe_q;
    err_pipe_d  = err_pipe_q;
    if (advance) begin
      vld_pipe_d  = {vld_pipe_q[0], src_vld};
      last_pipe_d = {last_pipe_q[0], src_last};
      err_pipe_d  = {err_pipe_q[0], !pe_instr_ok(pe_instr_t'(src_instr), cfg_q.is_dsa)};
    end
    acc_d = acc_q;
    if (out_fire) acc_d = last_pipe_q[1] ? 1'b0 : (acc_q | cur_fail);
    cfg_d = cfg_q;
    if (cfg_valid && cfg_ready) cfg_d = pe_cfg_from_alg(pe_alg_t'(cfg_alg));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      err_pipe_q  <= '0;
      acc_q       <= 1'b0;
      cfg_q       <= pe_cfg_from_alg(KEM_512);
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      err_pipe_q  <= err_pipe_d;
      acc_q       <= acc_d;
      cfg_q       <= cfg_d;
    end
  end

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    pe_modarith_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (advance),
      .cfg   (cfg_q),
      .instr (pe_instr_t'(src_instr)),
      .a     (src_a[i]),
      .b     (src_b[i]),
      .x     (lx[i]),
      .y     (ly[i]),
      .fail  (lfail[i])
    );
  end

  assign out_valid    = vld_pipe_q[1];
  assign out_last     = vld_pipe_q[1] && last_pipe_q[1];
  assign out_err      = vld_pipe_q[1] && err_pipe_q[1];
  assign out_chk_fail = vld_pipe_q[1] && last_pipe_q[1] && (acc_q || cur_fail);
  assign out_x        = lx;
  assign out_y        = ly;

endmodule

// File: tb/tb_pe_modarith_pipe.sv
// Directed bench for pe_modarith_pipe with hand-computed expectations.
module tb_pe_modarith_pipe;
  import pe_pkg::*;

  localparam int NUM = 4;
  localparam int WIDTH = 24;
  localparam int VW = NUM * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [4:0]    cfg_alg = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_instr = '0;
  logic          in_last = 1'b0;
  logic [VW-1:0] in_a = '0;
  logic [VW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] out_x, out_y;
  logic          out_last, out_chk_fail, out_err, busy;

  int total = 0;
  int bad   = 0;

  pe_modarith_pipe #(.NUM(NUM), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_alg(cfg_alg),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_last(in_last),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .out_chk_fail(out_chk_fail), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chkv(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {24'(e3), 24'(e2), 24'(e1), 24'(e0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [4:0] alg);
    cfg_alg = alg;
    cfg_valid = 1'b1;
    #1;
    chkb("cfg.ready", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] ins, input logic lst, input logic [VW-1:0] a, input logic [VW-1:0] b);
    in_instr = ins;
    in_last  = lst;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    #1;
    chkb("send.in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [4:0] ins, input logic lst,
                      input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [VW-1:0] ex, input logic [VW-1:0] ey,
                      input logic efail, input logic eerr);
    send(ins, lst, a, b);
    chkb({tag, ".early"}, out_valid, 1'b0);
    step();
    chkb({tag, ".valid"}, out_valid, 1'b1);
    chkv({tag, ".x"}, out_x, ex);
    chkv({tag, ".y"}, out_y, ey);
    chkb({tag, ".last"}, out_last, lst);
    chkb({tag, ".chkfail"}, out_chk_fail, efail);
    chkb({tag, ".err"}, out_err, eerr);
    step();
  endtask

  function automatic logic [VW-1:0] st_a(input int k);
    logic [VW-1:0] v;
    for (int i = 0; i < NUM; i++) v[i*WIDTH +: WIDTH] = 24'(k * 1000 + i * 7);
    return v;
  endfunction

  function automatic logic [VW-1:0] st_b(input int k);
    logic [VW-1:0] v;
    for (int i = 0; i < NUM; i++) v[i*WIDTH +: WIDTH] = 24'(8380000 - k);
    return v;
  endfunction

  function automatic logic [VW-1:0] st_x(input int k);
    logic [VW-1:0] v;
    longint s;
    for (int i = 0; i < NUM; i++) begin
      s = longint'(k * 1000 + i * 7) + longint'(8380000 - k);
      v[i*WIDTH +: WIDTH] = 24'(s % 64'd8380417);
    end
    return v;
  endfunction

  initial begin
    int sent, got, cyc, stall_n;
    logic [VW-1:0] held;

    // reset state
    #2;
    chkb("rst.cfg_ready", cfg_ready, 1'b1);
    chkb("rst.in_ready", in_ready, 1'b1);
    chkb("rst.out_valid", out_valid, 1'b0);
    chkb("rst.busy", busy, 1'b0);
    chkv("rst.out_x", out_x, '0);
    chkb("rst.chkfail", out_chk_fail, 1'b0);
    chkb("rst.err", out_err, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();

    // KEM_512 default
    beat("madd", MADD, 1'b1, pk(3000, 1, 3328, 0), pk(500, 2, 1, 0), pk(171, 3, 0, 0), '0, 1'b0, 1'b0);
    beat("msub", MSUB, 1'b1, pk(5, 10, 0, 7), pk(10, 5, 3328, 7), pk(3324, 5, 1, 0), '0, 1'b0, 1'b0);
    beat("kem_p2r", P2R, 1'b1, pk(1, 2, 3, 4), '0, '0, '0, 1'b0, 1'b1);

    cfg(DSA_44);
    beat("ctbfo", CT_BFO, 1'b1, pk(8380000, 0, 8380416, 1), pk(1000, 0, 8380416, 2),
         pk(583, 0, 8380415, 3), pk(8379000, 0, 0, 8380416), 1'b0, 1'b0);
    beat("p2r", P2R, 1'b1, pk(8380416, 4096, 4095, 4097), '0,
         pk(1023, 0, 0, 1), pk(0, 4096, 4095, 16773121), 1'b0, 1'b0);

    // CHKZ 4-beat packet, failing lane on beat 2
    beat("pkt.b1", CHKZ, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    beat("pkt.b2", CHKZ, 1'b0, pk(0, 0, 130994, 0), '0, pk(0, 0, 1, 0), '0, 1'b0, 1'b0);
    beat("pkt.b3", CHKZ, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    beat("pkt.b4", CHKZ, 1'b1, '0, '0, '0, '0, 1'b1, 1'b0);
    beat("bound", CHKZ, 1'b1, pk(130993, 130994, 8249423, 8249424), '0, pk(0, 1, 1, 0), '0, 1'b1, 1'b0);
    beat("clean", CHKZ, 1'b1, '0, '0, '0, '0, 1'b0, 1'b0);

    // back-to-back stream with a 3-cycle downstream stall
    sent = 0; got = 0; cyc = 0; stall_n = 0; held = '0;
    in_instr = MADD;
    in_last  = 1'b1;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      if (sent < 8) begin
        in_a = st_a(sent);
        in_b = st_b(sent);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        if (stall_n > 0) chkv("stream.hold", out_x, held);
        held = out_x;
        stall_n++;
`ifndef PE_IN_SKID_EN
        chkb("stream.in_ready_low", in_ready, 1'b0);
`endif
      end
      if (out_valid && out_ready) begin
        chkv("stream.x", out_x, st_x(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chki("stream.count", got, 8);
    chki("stream.stall_cycles", stall_n, 3);
    step();

    // config while busy is dropped
    send(CHKZ, 1'b1, pk(524091, 524092, 130994, 0), '0);
    cfg_alg = DSA_65;
    cfg_valid = 1'b1;
    #1;
    chkb("cfgbusy.ready", cfg_ready, 1'b0);
    step();
    cfg_valid = 1'b0;
    chkv("cfgbusy.x", out_x, pk(1, 1, 1, 0));
    step();
    beat("cfgbusy.again", CHKZ, 1'b1, pk(524091, 524092, 130994, 0), '0, pk(1, 1, 1, 0), '0, 1'b1, 1'b0);
    cfg(DSA_65);
    beat("dsa65", CHKZ, 1'b1, pk(524091, 524092, 130994, 0), '0, pk(0, 1, 0, 0), '0, 1'b1, 1'b0);
    beat("badop", 5'd31, 1'b1, pk(5, 6, 7, 8), pk(1, 1, 1, 1), '0, '0, 1'b0, 1'b1);

    // reset in the middle of a failing packet
    send(CHKH, 1'b0, pk(261888, 0, 0, 0), '0);
    step();
    send(CHKH, 1'b0, pk(261888, 0, 0, 0), '0);
    step();
    chkb("midrst.pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chkb("midrst.valid", out_valid, 1'b0);
    chkb("midrst.busy", busy, 1'b0);
    chkb("midrst.in_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    step();
    cfg(DSA_44);
    beat("postrst", CHKH, 1'b1, pk(95231, 0, 0, 0), '0, '0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
